uart_dbg_ctrl: RTL

- Command sequencer for the debug unit's word-wide UART.
- Pops 32-bit command words from the UART RX FIFO and decodes them.
- Drives the CPU control strobes and streams register-file and data-memory contents into the UART TX FIFO, respecting the FIFO flow-control flags.
- Sits between the UART (rx_empty/r_data/rd_uart, tx_full/w_data/wr_uart) and the MIPS core's debug port.

---
 rtl/uart_dbg_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_dbg_ctrl.sv
// uart_dbg_ctrl: debug-UART command sequencer driving CPU run/step/reset and dumping regs/memory to the TX FIFO.
// Define DBG_CHECKSUM_EN to append an XOR checksum word after every dump.
module uart_dbg_ctrl #(
   parameter int DBIT      = 32,
   parameter int REG_WORDS = 32,
   parameter int MEM_WORDS = 64,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_empty,
   input  logic [DBIT-1:0]   r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic [DBIT-1:0]   w_data,
   output logic              wr_uart,
   output logic              dbg_sel,
   output logic [ADDR_W-1:0] dbg_addr,
   input  logic [DBIT-1:0]   dbg_rd_data,
   output logic              cpu_run,
   output logic              cpu_step,
   output logic              cpu_rst,
   input  logic              cpu_halt,
   output logic              busy
);
   localparam logic [7:0] OP_RUN  = 8'h01;
   localparam logic [7:0] OP_STEP = 8'h02;
   localparam logic [7:0] OP_REGS = 8'h03;
   localparam logic [7:0] OP_MEM  = 8'h04;
   localparam logic [7:0] OP_RST  = 8'h05;

   typedef enum logic [2:0] {
      IDLE, DECODE, RUN_WAIT, RD_ISSUE, RD_WAIT, SEND, ACK
`ifdef DBG_CHECKSUM_EN
      , CKSUM
`endif
   } state_t;

   state_t            state_q;
   logic [7:0]        op_q;
   logic [ADDR_W-1:0] last_q;
   logic [DBIT-1:0]   w_data_q;
   logic              dbg_sel_q;
   logic [ADDR_W-1:0] dbg_addr_q;
   logic              cpu_run_q;
   logic              cpu_step_q;
   logic              cpu_rst_q;
   logic [ADDR_W-1:0] addr_d;
   logic              push_st;
   logic              unused_rdata;
`ifdef DBG_CHECKSUM_EN
   logic [DBIT-1:0]   acc_q;
   assign push_st = state_q inside {SEND, ACK, CKSUM};
`else
   assign push_st = state_q inside {SEND, ACK};
`endif

   assign addr_d       = dbg_addr_q + ADDR_W'(1);
   assign unused_rdata = ^r_data[DBIT-9:0];

   // FIFO strobes stay combinational so they qualify on the live rx_empty/tx_full flags.
   assign rd_uart  = state_q == IDLE && !rx_empty;
   assign wr_uart  = push_st && !tx_full;
   assign busy     = state_q != IDLE;
   assign w_data   = w_data_q;
   assign dbg_sel  = dbg_sel_q;
   assign dbg_addr = dbg_addr_q;
   assign cpu_run  = cpu_run_q;
   assign cpu_step = cpu_step_q;
   assign cpu_rst  = cpu_rst_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= '0;
         last_q     <= '0;
         w_data_q   <= '0;
         dbg_sel_q  <= 1'b0;
         dbg_addr_q <= '0;
         cpu_run_q  <= 1'b0;
         cpu_step_q <= 1'b0;
         cpu_rst_q  <= 1'b0;
`ifdef DBG_CHECKSUM_EN
         acc_q      <= '0;
`endif
      end else begin
         cpu_step_q <= 1'b0;
         cpu_rst_q  <= 1'b0;
         case (state_q)
            IDLE: if (!rx_empty) begin
               op_q    <= r_data[DBIT-1 -: 8];
               state_q <= DECODE;
            end
            DECODE: begin
               w_data_q <= DBIT'({8'hA5, op_q, 16'h0000});
`ifdef DBG_CHECKSUM_EN
               acc_q    <= '0;
`endif
               case (op_q)
                  OP_RUN: begin
                     cpu_run_q <= 1'b1;
                     state_q   <= RUN_WAIT;
                  end
                  OP_STEP: begin
                     cpu_step_q <= 1'b1;
                     state_q    <= ACK;
                  end
                  OP_RST: begin
                     cpu_rst_q <= 1'b1;
                     state_q   <= ACK;
                  end
                  OP_REGS, OP_MEM: begin
                     dbg_sel_q  <= op_q == OP_MEM;
                     dbg_addr_q <= '0;
                     last_q     <= op_q == OP_MEM ? ADDR_W'(MEM_WORDS - 1) : ADDR_W'(REG_WORDS - 1);
                     state_q    <= RD_ISSUE;
                  end
                  default: begin
                     w_data_q <= DBIT'({8'hFF, op_q, 16'h0000});
                     state_q  <= ACK;
                  end
               endcase
            end
            RUN_WAIT: if (cpu_halt) begin
               cpu_run_q <= 1'b0;
               state_q   <= ACK;
            end
            RD_ISSUE: state_q <= RD_WAIT;
            RD_WAIT: begin
               w_data_q <= dbg_rd_data;
`ifdef DBG_CHECKSUM_EN
               acc_q    <= acc_q ^ dbg_rd_data;
`endif
               state_q  <= SEND;
            end
            SEND: if (!tx_full) begin
               if (dbg_addr_q == last_q) begin
`ifdef DBG_CHECKSUM_EN
                  w_data_q <= acc_q;
                  state_q  <= CKSUM;
`else
                  state_q  <= IDLE;
`endif
               end else begin
                  dbg_addr_q <= addr_d;
                  state_q    <= RD_ISSUE;
               end
            end
            ACK: if (!tx_full) state_q <= IDLE;
`ifdef DBG_CHECKSUM_EN
            CKSUM: if (!tx_full) state_q <= IDLE;
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
